// File: rtl/la_pkg.sv
// Shared types for the logic-analyzer capture controller: FSM states, capture modes,
// the signed trigger-location type and the pre-trigger clamp helper.
package la_pkg;

    typedef enum logic [3:0] {
        ST_IDLE             = 4'd0,
        ST_MOVE_TO_POSITION = 4'd1,
        ST_IN_POSITION      = 4'd2,
        ST_CAPTURING        = 4'd3,
        ST_CAPTURED         = 4'd4
    } la_state_e;

    typedef enum logic [1:0] {
        MODE_SINGLE      = 2'd0,
        MODE_INCREMENTAL = 2'd1,
        MODE_IMMEDIATE   = 2'd2
    } la_mode_e;

    typedef logic signed [15:0] la_loc_t;

    // Pre-trigger sample count: negative -> 0, too large -> max_loc, none in incremental mode.
    function automatic logic [15:0] effective_pretrigger(input la_loc_t loc, input la_mode_e mode,
                                                         input logic [15:0] max_loc);
        logic [15:0] result;
        if (mode == MODE_INCREMENTAL || loc[15]) begin
            result = '0;
        end else if ($unsigned(loc) > max_loc) begin
            result = max_loc;
        end else begin
            result = $unsigned(loc);
        end
        return result;
    endfunction

endpackage

// File: rtl/la_capture_controller_if.sv
// Host/trigger/BRAM-side signal bundle of the capture controller.
// timed_out exists only when LA_TRIGGER_TIMEOUT_EN is defined.
interface la_capture_controller_if
    import la_pkg::*;
#(
    parameter int SAMPLE_DEPTH = 4096
);
    localparam int ADDR_WIDTH = $clog2(SAMPLE_DEPTH);

    logic                  request_start;
    logic                  request_stop;
    logic [1:0]            trigger_mode;
    la_loc_t               trigger_loc;
    logic                  trig;
    logic [3:0]            state;
    logic [15:0]           current_loc;
    logic [ADDR_WIDTH-1:0] read_pointer;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic                  bram_we;
`ifdef LA_TRIGGER_TIMEOUT_EN
    logic                  timed_out;

    modport master (
        output request_start, request_stop, trigger_mode, trigger_loc, trig,
        input  state, current_loc, read_pointer, bram_addr, bram_we, timed_out
    );
    modport slave (
        input  request_start, request_stop, trigger_mode, trigger_loc, trig,
        output state, current_loc, read_pointer, bram_addr, bram_we, timed_out
    );
`else
    modport master (
        output request_start, request_stop, trigger_mode, trigger_loc, trig,
        input  state, current_loc, read_pointer, bram_addr, bram_we
    );
    modport slave (
        input  request_start, request_stop, trigger_mode, trigger_loc, trig,
        output state, current_loc, read_pointer, bram_addr, bram_we
    );
`endif

endinterface

// File: rtl/la_ring_pointer.sv
// Wrap-around buffer pointer with synchronous clear (priority) and increment.
module la_ring_pointer #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] ptr_o
);
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/la_capture_controller.sv
// Ring-buffer capture controller: pre-trigger fill, arm, post-trigger capture, BRAM write control.
// Define LA_TRIGGER_TIMEOUT_EN to add TIMEOUT_CYCLES and timed_out (forced trigger when armed too long).
module la_capture_controller
    import la_pkg::*;
#(
    parameter int SAMPLE_DEPTH = 4096
`ifdef LA_TRIGGER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    la_capture_controller_if.slave ctrl
);
    localparam int          ADDR_WIDTH = $clog2(SAMPLE_DEPTH);
    localparam logic [15:0] LAST_LOC   = 16'(SAMPLE_DEPTH - 1);

    la_state_e             state_q, state_d;
    la_mode_e              mode_q, mode_d;
    la_mode_e              req_mode;
    logic [15:0]           pre_q, pre_d;
    logic [15:0]           loc_q, loc_d;
    logic                  we;
    logic                  rd_inc;
    logic                  ptr_clear;
    logic                  start_ok;
    logic                  timeout_hit;
    logic [1:0]            ptr_inc;
    logic [ADDR_WIDTH-1:0] ptr_val [2];

    assign req_mode = (ctrl.trigger_mode == 2'd3) ? MODE_SINGLE : la_mode_e'(ctrl.trigger_mode);
    assign start_ok = ctrl.request_start && !ctrl.request_stop &&
                      (state_q == ST_IDLE || state_q == ST_CAPTURED);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pre_d     = pre_q;
        loc_d     = loc_q;
        we        = 1'b0;
        rd_inc    = 1'b0;
        ptr_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ptr_clear = 1'b1;
                loc_d     = '0;
            end
            ST_MOVE_TO_POSITION: begin
                we = (pre_q != '0);
                if (!we || loc_q == pre_q - 16'd1) begin
                    state_d = ST_IN_POSITION;
                end
            end
            ST_IN_POSITION: begin
                we = (mode_q != MODE_INCREMENTAL) || ctrl.trig;
                if (mode_q != MODE_SINGLE || ctrl.trig || timeout_hit) begin
                    // With P = depth-1 the trigger sample already fills the buffer.
                    state_d = (we && loc_q == LAST_LOC) ? ST_CAPTURED : ST_CAPTURING;
                end else begin
                    rd_inc = 1'b1;
                end
            end
            ST_CAPTURING: begin
                we = (mode_q != MODE_INCREMENTAL) || ctrl.trig;
                if (we && loc_q == LAST_LOC) begin
                    state_d = ST_CAPTURED;
                end
            end
            ST_CAPTURED: begin
                we = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Sliding pre-trigger window: count stays at P while the oldest pointer follows.
        if (we && !rd_inc) begin
            loc_d = loc_q + 16'd1;
        end

        if (start_ok) begin
            state_d   = ST_MOVE_TO_POSITION;
            mode_d    = req_mode;
            pre_d     = effective_pretrigger(ctrl.trigger_loc, req_mode, LAST_LOC);
            loc_d     = '0;
            ptr_clear = 1'b1;
        end

        if (ctrl.request_stop) begin
            state_d   = ST_IDLE;
            loc_d     = '0;
            ptr_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_SINGLE;
            pre_q   <= '0;
            loc_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pre_q   <= pre_d;
            loc_q   <= loc_d;
        end
    end

    // Index 0 is the write pointer, index 1 the oldest-sample pointer.
    assign ptr_inc = {rd_inc, we};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
        la_ring_pointer #(
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_ptr (
            .clk     (clk),
            .rst     (rst),
            .clear_i (ptr_clear),
            .inc_i   (ptr_inc[gi]),
            .ptr_o   (ptr_val[gi])
        );
    end

`ifdef LA_TRIGGER_TIMEOUT_EN
    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   timed_out_q, timed_out_d;

    assign timeout_hit = (state_q == ST_IN_POSITION) &&
                         (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        timer_d     = (state_q == ST_IN_POSITION) ? timer_q + TIMER_WIDTH'(1) : '0;
        timed_out_d = timed_out_q;
        if (timeout_hit && mode_q == MODE_SINGLE && !ctrl.trig) begin
            timed_out_d = 1'b1;
        end
        if (start_ok || ctrl.request_stop) begin
            timed_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q     <= '0;
            timed_out_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign ctrl.timed_out = timed_out_q;
`else
    assign timeout_hit = 1'b0;
`endif

    assign ctrl.state        = state_q;
    assign ctrl.current_loc  = loc_q;
    assign ctrl.bram_we      = we;
    assign ctrl.bram_addr    = ptr_val[0];
    assign ctrl.read_pointer = ptr_val[1];

endmodule

// File: tb/tb_la_capture_controller.sv
// Randomized self-checking bench for la_capture_controller (SAMPLE_DEPTH=16) against a
// schedule-level ring-buffer model; LA_TRIGGER_TIMEOUT_EN also exercises the forced trigger.
module tb_la_capture_controller;
    import la_pkg::*;

    localparam int DEPTH   = 16;
    localparam int MAX_CYC = 300;
`ifdef LA_TRIGGER_TIMEOUT_EN
    localparam int MAX_WAIT = 6;
`else
    localparam int MAX_WAIT = 12;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    bit   trig_pat [0:MAX_CYC];
    int   exp_cyc [$];
    int   obs_cyc [$];
    int   obs_addr [$];

    always #5 clk = ~clk;

    la_capture_controller_if #(.SAMPLE_DEPTH(DEPTH)) bus ();

    la_capture_controller #(
        .SAMPLE_DEPTH(DEPTH)
`ifdef LA_TRIGGER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_pre(input int mode, input int tloc);
        if (mode == 1 || tloc < 0) return 0;
        if (tloc > DEPTH - 1) return DEPTH - 1;
        return tloc;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_state"}, 32'(bus.state), 0);
        check({tag, "_loc"}, 32'(bus.current_loc), 0);
        check({tag, "_rdptr"}, 32'(bus.read_pointer), 0);
        check({tag, "_wrptr"}, 32'(bus.bram_addr), 0);
        check({tag, "_we"}, 32'(bus.bram_we), 0);
    endtask

    // One full capture from IDLE/CAPTURED; w = IN_POSITION cycles before the trigger cycle.
    task automatic run_capture(input int mode, input int tloc, input int w, input bit no_trig,
                               input bit pat58, input bit exp_to);
        int mm, p, inpos, done_k, mism, n, trig_addr;
        mm    = (mode == 3) ? 0 : mode;
        p     = eff_pre(mm, tloc);
        inpos = (p == 0) ? 2 : p + 1;
        if (mm == 2) w = 0;
        exp_cyc.delete();
        obs_cyc.delete();
        obs_addr.delete();
        for (int k = 0; k <= MAX_CYC; k++) begin
            if (mm == 1)              trig_pat[k] = pat58 ? ((k % 8) < 5) : ($urandom_range(0, 7) < 5);
            else if (k < inpos)       trig_pat[k] = 1'($urandom_range(0, 1));
            else if (k < inpos + w)   trig_pat[k] = 1'b0;
            else if (k == inpos + w)  trig_pat[k] = !no_trig;
            else                      trig_pat[k] = no_trig ? 1'b0 : 1'($urandom_range(0, 1));
        end
        if (mm == 1) begin
            for (int k = 2; k <= MAX_CYC && exp_cyc.size() < DEPTH; k++)
                if (trig_pat[k]) exp_cyc.push_back(k);
        end else begin
            for (int k = 1; k <= p; k++) exp_cyc.push_back(k);
            for (int j = 0; j < w + DEPTH - p; j++) exp_cyc.push_back(inpos + j);
        end
        n = exp_cyc.size();

        bus.trigger_mode  = 2'(mode);
        bus.trigger_loc   = 16'(tloc);
        bus.request_start = 1'b1;
        bus.trig          = trig_pat[0];
        step();
        done_k = -1;
        for (int k = 1; k <= MAX_CYC && done_k < 0; k++) begin
            bus.request_start = (k == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.trigger_mode  = 2'($urandom_range(0, 3));
            bus.trigger_loc   = 16'($urandom_range(0, 65535));
            bus.trig          = trig_pat[k];
            @(negedge clk);
`ifdef LA_TRIGGER_TIMEOUT_EN
            if (k == 1) check("to_cleared", 32'(bus.timed_out), 0);
`endif
            if (k == inpos) begin
                check("state_inpos", 32'(bus.state), 2);
                check("loc_inpos", 32'(bus.current_loc), 32'(p));
            end
            if (bus.bram_we) begin
                obs_cyc.push_back(k);
                obs_addr.push_back(int'(bus.bram_addr));
            end
            if (bus.state == 4'd4) done_k = k;
            step();
        end
        bus.trig          = 1'b0;
        bus.request_start = 1'b0;
        @(negedge clk);

        check("done_seen", 32'(done_k >= 0), 1);
        check("n_writes", 32'(obs_cyc.size()), 32'(n));
        mism = 0;
        for (int i = 0; i < obs_cyc.size() && i < n; i++)
            if (obs_cyc[i] != exp_cyc[i] || obs_addr[i] != i % DEPTH) mism++;
        check("wr_sched", 32'(mism), 0);
        check("done_cyc", 32'(done_k), 32'(exp_cyc[n-1] + 1));
        check("end_state", 32'(bus.state), 4);
        check("end_loc", 32'(bus.current_loc), DEPTH);
        check("end_rdptr", 32'(bus.read_pointer), 32'(n % DEPTH));
        check("end_wrptr", 32'(bus.bram_addr), 32'(n % DEPTH));
        check("end_we", 32'(bus.bram_we), 0);
        if (mm != 1) begin
            trig_addr = -1;
            for (int i = 0; i < obs_cyc.size(); i++)
                if (obs_cyc[i] == inpos + w) trig_addr = obs_addr[i];
            check("trig_addr", 32'(trig_addr), 32'((n + p) % DEPTH));
        end
`ifdef LA_TRIGGER_TIMEOUT_EN
        check("timed_out", 32'(bus.timed_out), 32'(exp_to));
`else
        if (exp_to) check("to_unsupported", 0, 1);
`endif
        $display("[TB] capture mode=%0d loc=%0d P=%0d wait=%0d writes=%0d done@%0d",
                 mode, tloc, p, w, obs_cyc.size(), done_k);
    endtask

    initial begin
        rst               = 1'b1;
        bus.request_start = 1'b0;
        bus.request_stop  = 1'b0;
        bus.trigger_mode  = 2'd0;
        bus.trigger_loc   = '0;
        bus.trig          = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("reset");
        $display("[TB] reset released");

        // Simultaneous start and stop in IDLE: stop wins.
        step();
        bus.request_start = 1'b1;
        bus.request_stop  = 1'b1;
        step();
        bus.request_start = 1'b0;
        bus.request_stop  = 1'b0;
        @(negedge clk);
        check("startstop_state", 32'(bus.state), 0);
        check("startstop_we", 32'(bus.bram_we), 0);
        $display("[TB] start+stop in IDLE");
        step();

        run_capture(0, 4, (10 > MAX_WAIT) ? MAX_WAIT : 10, 1'b0, 1'b0, 1'b0);
        run_capture(0, -3, 3, 1'b0, 1'b0, 1'b0);
        run_capture(0, 20, 2, 1'b0, 1'b0, 1'b0);
        run_capture(2, 0, 0, 1'b0, 1'b0, 1'b0);
        run_capture(1, 5, 0, 1'b0, 1'b1, 1'b0);
        run_capture(3, 6, 4, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 12; r++)
            run_capture(int'($urandom_range(0, 3)), int'($urandom_range(0, 32)) - 8,
                        int'($urandom_range(0, MAX_WAIT)), 1'b0, 1'b0, 1'b0);

        // Stop mid-capture: SINGLE, P=2, trigger on first IN_POSITION cycle -> loc 7 at cycle 8.
        bus.trigger_mode  = 2'd0;
        bus.trigger_loc   = 16'sd2;
        bus.request_start = 1'b1;
        step();
        bus.request_start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            bus.trig = (k == 3);
            step();
        end
        bus.trig = 1'b0;
        @(negedge clk);
        check("pre_stop_state", 32'(bus.state), 3);
        check("pre_stop_loc", 32'(bus.current_loc), 7);
        bus.request_stop = 1'b1;
        step();
        bus.request_stop = 1'b0;
        @(negedge clk);
        check("stop_state", 32'(bus.state), 0);
        check("stop_we", 32'(bus.bram_we), 0);
        step();
        @(negedge clk);
        check_idle_zero("stop_idle");
        $display("[TB] stop during CAPTURING");

        // Reset mid-capture: IMMEDIATE, P=0 -> CAPTURING from cycle 3.
        bus.trigger_mode  = 2'd2;
        bus.trigger_loc   = 16'sd0;
        bus.request_start = 1'b1;
        step();
        bus.request_start = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("pre_rst_state", 32'(bus.state), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("rst_capt");
        $display("[TB] reset during CAPTURING");
        step();

`ifdef LA_TRIGGER_TIMEOUT_EN
        run_capture(0, 3, 7, 1'b1, 1'b0, 1'b1);
        run_capture(0, 3, 1, 1'b0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
